// File: rtl/pipe_buf_pkg.sv
// Shared constants and width helpers for the pipe_buf stream buffer.
package pipe_buf_pkg;

  localparam int unsigned DefaultW     = 8;
  localparam int unsigned DefaultDepth = 4;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Wrapping index counter 0..DEPTH-1 with synchronous clear and async active-high reset.
module pipe_buf_ptr
  import pipe_buf_pkg::*;
#(
  parameter int unsigned  DEPTH = DefaultDepth,
  localparam int unsigned PW    = ptr_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] Last = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  // Explicit wrap compare so non-power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == Last) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_buf.sv
// First-word fall-through stream FIFO with valid/ready on both sides.
// Optional FLUSH port enabled by defining PIPE_BUF_FLUSH_EN.
module pipe_buf
  import pipe_buf_pkg::*;
#(
  parameter int unsigned  W     = DefaultW,
  parameter int unsigned  DEPTH = DefaultDepth,
  localparam int unsigned CW    = cnt_width(DEPTH),
  localparam int unsigned PW    = ptr_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [W-1:0]  IN_DATA,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic [W-1:0]  OUT_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [CW-1:0] COUNT
`ifdef PIPE_BUF_FLUSH_EN
  ,
  input  logic          FLUSH
`endif
);

  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic          flush;
  logic          push, pop;
  logic          ready_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  mem [DEPTH];

`ifdef PIPE_BUF_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  // Holds IN_READY low until the first edge after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign IN_READY  = ready_q & ~RST & (count_q != Full);
  assign OUT_VALID = (count_q != '0);
  assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : '0;
  assign COUNT     = count_q;

  // Flush overrides any transfer on the same edge.
  assign push = IN_VALID & IN_READY & ~flush;
  assign pop  = OUT_VALID & OUT_READY & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= IN_DATA;
    end
  end

  pipe_buf_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .CLK (CLK),
    .RST (RST),
    .inc (push),
    .clr (flush),
    .ptr (wr_ptr)
  );

  pipe_buf_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .CLK (CLK),
    .RST (RST),
    .inc (pop),
    .clr (flush),
    .ptr (rd_ptr)
  );

endmodule

// File: tb/tb_pipe_buf.sv
// Directed bench for pipe_buf: a DEPTH=4 instance and a DEPTH=3 instance for wrap checks.
module tb_pipe_buf;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] in_data4, out_data4;
  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [2:0] count4;

  logic [7:0] in_data3, out_data3;
  logic       in_valid3, in_ready3, out_valid3, out_ready3;
  logic [1:0] count3;

`ifdef PIPE_BUF_FLUSH_EN
  logic       flush4;
  logic       flush3;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] model_q[$];

  always #5 clk = ~clk;

  pipe_buf #(
    .W     (8),
    .DEPTH (4)
  ) u_dut4 (
    .CLK       (clk),
    .RST       (rst),
    .IN_DATA   (in_data4),
    .IN_VALID  (in_valid4),
    .IN_READY  (in_ready4),
    .OUT_DATA  (out_data4),
    .OUT_VALID (out_valid4),
    .OUT_READY (out_ready4),
    .COUNT     (count4)
`ifdef PIPE_BUF_FLUSH_EN
    ,
    .FLUSH     (flush4)
`endif
  );

  pipe_buf #(
    .W     (8),
    .DEPTH (3)
  ) u_dut3 (
    .CLK       (clk),
    .RST       (rst),
    .IN_DATA   (in_data3),
    .IN_VALID  (in_valid3),
    .IN_READY  (in_ready3),
    .OUT_DATA  (out_data3),
    .OUT_VALID (out_valid3),
    .OUT_READY (out_ready3),
    .COUNT     (count3)
`ifdef PIPE_BUF_FLUSH_EN
    ,
    .FLUSH     (flush3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int cnt, input logic [7:0] head, input logic rdy);
    chk({tag, ".count"}, 32'(count4), 32'(cnt));
    chk({tag, ".valid"}, 32'(out_valid4), 32'(cnt != 0));
    chk({tag, ".data"}, 32'(out_data4), 32'(head));
    chk({tag, ".in_ready"}, 32'(in_ready4), 32'(rdy));
  endtask

  // One cycle on the DEPTH=3 instance, checked against a queue model.
  task automatic wstep(input logic v, input logic r, input logic [7:0] d);
    logic do_push, do_pop;
    in_valid3  = v;
    out_ready3 = r;
    in_data3   = d;
    do_push = v && (model_q.size() < 3);
    do_pop  = r && (model_q.size() > 0);
    chk("wrap.in_ready", 32'(in_ready3), 32'(model_q.size() < 3));
    tick();
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    chk("wrap.count", 32'(count3), 32'(model_q.size()));
    chk("wrap.data", 32'(out_data3), (model_q.size() > 0) ? 32'(model_q[0]) : 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    in_data4   = '0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b0;
    in_data3   = '0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b0;
`ifdef PIPE_BUF_FLUSH_EN
    flush4 = 1'b0;
    flush3 = 1'b0;
`endif

    // Reset state
    tick();
    chk4("rst", 0, 8'h00, 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_rel.in_ready", 32'(in_ready4), 32'h1);

    // Async reset mid-stream with three entries held
    in_valid4 = 1'b1;
    in_data4 = 8'hA1; tick();
    in_data4 = 8'hA2; tick();
    in_data4 = 8'hA3; tick();
    in_valid4 = 1'b0;
    chk4("pre_rst", 3, 8'hA1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk4("async_rst", 0, 8'h00, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk("rst_rel2.in_ready", 32'(in_ready4), 32'h1);

    // Fill to DEPTH with consumer stalled
    in_valid4 = 1'b1;
    in_data4 = 8'h11; tick();
    chk4("fill1", 1, 8'h11, 1'b1);
    in_data4 = 8'h22; tick();
    in_data4 = 8'h33; tick();
    in_data4 = 8'h44; tick();
    chk4("fill4", 4, 8'h11, 1'b0);
    in_data4 = 8'h55; tick();
    chk4("full_hold", 4, 8'h11, 1'b0);

    // Full + pop: pop only, the held 0x55 is not taken this edge
    out_ready4 = 1'b1;
    tick();
    chk4("full_pop", 3, 8'h22, 1'b1);
    tick();
    chk4("push_pop", 3, 8'h33, 1'b1);
    in_valid4 = 1'b0;
    tick();
    chk4("drain44", 2, 8'h44, 1'b1);
    tick();
    chk4("drain55", 1, 8'h55, 1'b1);
    tick();
    chk4("empty", 0, 8'h00, 1'b1);

    // Streaming ramp, one-cycle latency, steady occupancy of one
    in_valid4 = 1'b1;
    in_data4  = 8'h00;
    tick();
    chk4("ramp0", 1, 8'h00, 1'b1);
    for (int i = 1; i < 256; i++) begin
      in_data4 = 8'(i);
      tick();
      chk("ramp.data", 32'(out_data4), 32'(i));
      chk("ramp.count", 32'(count4), 32'h1);
    end
    in_valid4 = 1'b0;
    tick();
    chk4("ramp_end", 0, 8'h00, 1'b1);
    out_ready4 = 1'b0;

    // Non-power-of-two depth, pointers cross index 2 -> 0
    wstep(1'b1, 1'b0, 8'h01);
    wstep(1'b1, 1'b0, 8'h02);
    wstep(1'b1, 1'b0, 8'h03);
    wstep(1'b1, 1'b1, 8'h04);
    wstep(1'b1, 1'b1, 8'h05);
    wstep(1'b0, 1'b1, 8'h00);
    wstep(1'b1, 1'b0, 8'h06);
    wstep(1'b1, 1'b1, 8'h07);
    wstep(1'b1, 1'b1, 8'h08);
    wstep(1'b0, 1'b1, 8'h00);
    wstep(1'b0, 1'b1, 8'h00);
    wstep(1'b0, 1'b1, 8'h00);
    in_valid3  = 1'b0;
    out_ready3 = 1'b0;

`ifdef PIPE_BUF_FLUSH_EN
    // Flush discards contents and beats a same-edge push
    in_valid4 = 1'b1;
    in_data4 = 8'hC1; tick();
    in_data4 = 8'hC2; tick();
    chk4("pre_flush", 2, 8'hC1, 1'b1);
    in_data4 = 8'hAA;
    flush4   = 1'b1;
    #1;
    chk("flush.in_ready", 32'(in_ready4), 32'h1);
    tick();
    flush4    = 1'b0;
    in_valid4 = 1'b0;
    chk4("flush", 0, 8'h00, 1'b1);
    tick();
    chk4("post_flush", 0, 8'h00, 1'b1);
    in_valid4 = 1'b1;
    in_data4  = 8'h5A;
    tick();
    in_valid4 = 1'b0;
    chk4("flush_reuse", 1, 8'h5A, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
